// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, coordinate types and small helpers for the
// frame-buffer scan-out path. Defaults describe 640x480 @ 60 Hz with a
// 25 MHz pixel rate derived from a 50 MHz system clock.
package vga_timing_pkg;

  // Coordinate and pixel widths shared with the frame buffer read port
  localparam int COORD_W = 11;
  localparam int PIX_W   = 8;

  // Default horizontal timing, in pixels
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  // Default vertical timing, in lines
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [PIX_W-1:0]   pix_t;

  // Region flags for the pixel currently addressed by the counters
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } region_t;

  // True when c lies in the half-open window [lo, hi)
  function automatic logic in_window(input coord_t c, input coord_t lo, input coord_t hi);
    return (c >= lo) && (c < hi);
  endfunction

  // Drive level of a sync line given whether sync is asserted and its polarity
  function automatic logic sync_level(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-rate enable, horizontal/vertical counters and region decode.
// Counters advance only on cycles where the pixel tick is high, so each
// pixel address is held for two system clocks.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic    i_clk,
  input  logic    i_reset,
  output logic    o_pix_tick,
  output coord_t  o_h_cnt,
  output coord_t  o_v_cnt,
  output region_t o_region,
  output logic    o_frame_wrap
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT_END  = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT_END  = coord_t'(V_ACTIVE);
  localparam coord_t HS_START   = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END     = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_START   = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END     = coord_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam coord_t COORD_ZERO = coord_t'(0);
  localparam coord_t COORD_ONE  = coord_t'(1);

  logic    r_pix_tick;
  coord_t  r_h_cnt;
  coord_t  r_v_cnt;
  logic    w_h_last;
  logic    w_v_last;
  region_t w_region;

  // Pixel enable toggles every clock; counters step on the high phase
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pix_tick <= 1'b0;
      r_h_cnt    <= COORD_ZERO;
      r_v_cnt    <= COORD_ZERO;
    end else begin
      r_pix_tick <= ~r_pix_tick;
      if (r_pix_tick) begin
        if (w_h_last) begin
          r_h_cnt <= COORD_ZERO;
          if (w_v_last) begin
            r_v_cnt <= COORD_ZERO;
          end else begin
            r_v_cnt <= r_v_cnt + COORD_ONE;
          end
        end else begin
          r_h_cnt <= r_h_cnt + COORD_ONE;
        end
      end
    end
  end

  // Decode end-of-line/frame and the region the current address falls in
  always_comb begin
    w_h_last        = 1'b0;
    w_v_last        = 1'b0;
    w_region        = '0;
    w_h_last        = (r_h_cnt == H_LAST);
    w_v_last        = (r_v_cnt == V_LAST);
    w_region.active = (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);
    w_region.hs     = in_window(r_h_cnt, HS_START, HS_END);
    w_region.vs     = in_window(r_v_cnt, VS_START, VS_END);
  end

  assign o_pix_tick   = r_pix_tick;
  assign o_h_cnt      = r_h_cnt;
  assign o_v_cnt      = r_v_cnt;
  assign o_region     = w_region;
  assign o_frame_wrap = r_pix_tick & w_h_last & w_v_last;

endmodule

// File: rtl/vga_buffer_reader.sv
// Frame-buffer scan-out: presents read coordinates to the buffer, absorbs
// its one-cycle registered read latency and drives aligned pixel, sync and
// blank signals to the video DAC.
module vga_buffer_reader
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [PIX_W-1:0]   rd_data,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  output logic [PIX_W-1:0]   VGA_R,
  output logic [PIX_W-1:0]   VGA_G,
  output logic [PIX_W-1:0]   VGA_B,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_BLANK_N,
  output logic               VGA_SYNC_N,
  output logic               VGA_CLK,
  output logic               frame_start
);

  logic    w_pix_tick;
  coord_t  w_h_cnt;
  coord_t  w_v_cnt;
  region_t w_region;
  logic    w_frame_wrap;

  pix_t    r_pixel;
  logic    r_hs;
  logic    r_vs;
  logic    r_blank_n;
  logic    r_frame_start;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .i_clk        (CLOCK_50),
    .i_reset      (reset),
    .o_pix_tick   (w_pix_tick),
    .o_h_cnt      (w_h_cnt),
    .o_v_cnt      (w_v_cnt),
    .o_region     (w_region),
    .o_frame_wrap (w_frame_wrap)
  );

  // Read address follows the counters in active video and parks at 0 in blanking
  always_comb begin
    rd_x = '0;
    rd_y = '0;
    if (w_region.active) begin
      rd_x = w_h_cnt;
      rd_y = w_v_cnt;
    end else begin
      rd_x = '0;
      rd_y = '0;
    end
  end

  // Output stage: capture buffer data with the flags of the same address one pixel later
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_pixel       <= '0;
      r_hs          <= ~SYNC_POL;
      r_vs          <= ~SYNC_POL;
      r_blank_n     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_wrap;
      if (w_pix_tick) begin
        r_pixel   <= w_region.active ? rd_data : '0;
        r_hs      <= sync_level(w_region.hs, SYNC_POL);
        r_vs      <= sync_level(w_region.vs, SYNC_POL);
        r_blank_n <= w_region.active;
      end
    end
  end

  assign VGA_R       = r_pixel;
  assign VGA_G       = r_pixel;
  assign VGA_B       = r_pixel;
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign VGA_BLANK_N = r_blank_n;
  assign VGA_SYNC_N  = 1'b0;
  // DAC samples in the middle of each two-clock pixel
  assign VGA_CLK     = ~w_pix_tick;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_buffer_reader.sv
// Self-checking bench for vga_buffer_reader using a reduced raster so that
// several frames fit in a short run. A registered buffer model returns x^y
// (or a constant during the first frame); expected outputs are derived from
// the clock count since reset and checked through a one-pixel scoreboard.
module tb_vga_buffer_reader;

  localparam int TB_HA  = 16;
  localparam int TB_HF  = 2;
  localparam int TB_HSW = 4;
  localparam int TB_HB  = 3;
  localparam int TB_VA  = 8;
  localparam int TB_VF  = 1;
  localparam int TB_VSW = 2;
  localparam int TB_VB  = 2;
  localparam int HT     = TB_HA + TB_HF + TB_HSW + TB_HB;   // 25
  localparam int VT     = TB_VA + TB_VF + TB_VSW + TB_VB;   // 13
  localparam int FPIX   = HT * VT;                          // pixels per frame
  localparam int K_RST  = 2 * (2 * FPIX + 3 * HT + 5);      // clock index of pixel (5,3) in frame 2

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic [7:0]  rd_data;
  logic [10:0] rd_x;
  logic [10:0] rd_y;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_BLANK_N;
  logic        VGA_SYNC_N;
  logic        VGA_CLK;
  logic        frame_start;

  logic        const_mode;
  int          n_vec;
  int          n_err;
  int          k_cur;

  typedef struct packed {
    logic [7:0] pix;
    logic       hs;
    logic       vs;
    logic       bn;
  } exp_t;

  exp_t q[$];

  vga_buffer_reader #(
    .H_ACTIVE (TB_HA),
    .H_FP     (TB_HF),
    .H_SYNC   (TB_HSW),
    .H_BP     (TB_HB),
    .V_ACTIVE (TB_VA),
    .V_FP     (TB_VF),
    .V_SYNC   (TB_VSW),
    .V_BP     (TB_VB),
    .SYNC_POL (1'b0)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .rd_data     (rd_data),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_N (VGA_BLANK_N),
    .VGA_SYNC_N  (VGA_SYNC_N),
    .VGA_CLK     (VGA_CLK),
    .frame_start (frame_start)
  );

  // 50 MHz system clock
  always #10 CLOCK_50 = ~CLOCK_50;

  // Frame buffer model with a one-cycle registered read
  always @(posedge CLOCK_50) begin
    rd_data <= const_mode ? 8'hAA : (rd_x[7:0] ^ rd_y[7:0]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k_cur, obs, exp);
    end
  endtask

  // Check everything visible at sample k (k = clock edges since the last reset edge)
  task automatic check_sample(input int k);
    int   p;
    int   h;
    int   v;
    logic act;
    exp_t e;
    exp_t got;
    p     = k / 2;
    h     = p % HT;
    v     = (p / HT) % VT;
    act   = (h < TB_HA) && (v < TB_VA);
    k_cur = k;
    chk("rd_x", 32'(rd_x), act ? 32'(h) : 32'd0);
    chk("rd_y", 32'(rd_y), act ? 32'(v) : 32'd0);
    chk("vga_clk", 32'(VGA_CLK), (k % 2 == 0) ? 32'd1 : 32'd0);
    chk("sync_n", 32'(VGA_SYNC_N), 32'd0);
    chk("frame_start", 32'(frame_start),
        (k > 0 && k % 2 == 0 && p % FPIX == 0) ? 32'd1 : 32'd0);
    if (k % 2 == 0) begin
      e.pix = act ? (const_mode ? 8'hAA : 8'((h ^ v) & 255)) : 8'h00;
      e.hs  = !((h >= TB_HA + TB_HF) && (h < TB_HA + TB_HF + TB_HSW));
      e.vs  = !((v >= TB_VA + TB_VF) && (v < TB_VA + TB_VF + TB_VSW));
      e.bn  = act;
      if (k >= 2) begin
        got = q.pop_front();
      end else begin
        got = '{pix: 8'h00, hs: 1'b1, vs: 1'b1, bn: 1'b0};
      end
      chk("vga_r", 32'(VGA_R), 32'(got.pix));
      chk("vga_g", 32'(VGA_G), 32'(got.pix));
      chk("vga_b", 32'(VGA_B), 32'(got.pix));
      chk("vga_hs", 32'(VGA_HS), 32'(got.hs));
      chk("vga_vs", 32'(VGA_VS), 32'(got.vs));
      chk("blank_n", 32'(VGA_BLANK_N), 32'(got.bn));
      q.push_back(e);
    end
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    k_cur      = 0;
    reset      = 1'b1;
    const_mode = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;

    // Phase 1: two frames plus part of a third; constant data until first vertical blank
    for (int k = 0; k <= K_RST; k++) begin
      check_sample(k);
      if (const_mode && (((k / 2) / HT) % VT >= TB_VA)) const_mode = 1'b0;
      if (k < K_RST) @(negedge CLOCK_50);
    end

    // Phase 2: one-cycle reset with counters at (5,3)
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    q.delete();

    // Phase 3: restart from (0,0) and run past the next frame wrap
    for (int k = 0; k <= 2 * FPIX + 20; k++) begin
      check_sample(k);
      @(negedge CLOCK_50);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_buffer_reader.md
# vga_buffer_reader

Scan-out side of the per-channel frame buffers. Generates 640x480 @ 60 Hz VGA timing from CLOCK_50 with a 25 MHz pixel enable, drives the buffer read coordinates, absorbs the buffer's one-cycle registered read latency, and presents aligned pixel/sync/blank signals to the DAC. It is the counterpart of the camera-side writer: the writer fills the buffer via its write port, this block consumes the read port.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, asserted level of VGA_HS/VGA_VS

Ports (one clock; reset is synchronous and active-high):
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous, active-high
- rd_data  in  8  buffer read data, valid one CLOCK_50 cycle after rd_x/rd_y
- rd_x  out  11  buffer read column
- rd_y  out  11  buffer read row
- VGA_R, VGA_G, VGA_B  out  8 each  pixel intensity (all three driven from rd_data, grayscale)
- VGA_HS  out  1  horizontal sync
- VGA_VS  out  1  vertical sync
- VGA_BLANK_N  out  1  high during active video
- VGA_SYNC_N  out  1  constant 0
- VGA_CLK  out  1  pixel clock to DAC
- frame_start  out  1  one-cycle pulse at start of each frame

## Operation
- pix_tick: toggle register, 0 after reset, inverts every cycle; counters and outputs advance only on cycles with pix_tick=1.
- h_cnt 0..H_TOTAL-1 (H_TOTAL=800); on pix_tick at H_TOTAL-1 wraps to 0 and v_cnt increments; v_cnt 0..V_TOTAL-1 (V_TOTAL=525) wraps to 0 after V_TOTAL-1.
- Regions: active when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE. HS asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); VS asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- rd_x/rd_y = h_cnt/v_cnt when active, else 0 (combinational from counters; never out of buffer range).
- Output stage (updates on pix_tick=1): VGA_R/G/B = rd_data if the delayed active flag is 1, else 0; VGA_HS/VS/BLANK_N take the delayed region flags of the pixel whose address was presented.
- frame_start: high for exactly one CLOCK_50 cycle, the cycle after the counters wrap to (0,0).
- VGA_CLK = ~pix_tick (DAC samples mid-pixel).

## Timing
- Reset values: h_cnt=v_cnt=0, pix_tick=0, VGA_R/G/B=0, VGA_HS=VGA_VS=!SYNC_POL, VGA_BLANK_N=0, frame_start=0, VGA_CLK=1.
- Counters hold 2 cycles per pixel; rd_data for address (x,y) is stable by the second cycle and captured at the next pix_tick. Pixel (x,y) appears at the outputs exactly one pixel period (2 CLOCK_50 cycles) after counters show (x,y); sync/blank delayed identically.
- Line = 1600 cycles, frame = 840000 cycles.
- Reset mid-frame: next cycle all state at reset values; first post-reset pix_tick is cycle 2; frame_start does not pulse on reset.
- Simultaneous h and v wrap at (799,524): both go to 0 on the same pix_tick.

## Structure
- Package vga_timing_pkg: default timing constants, H_TOTAL/V_TOTAL derived, coordinate width (11).
- Sub-module vga_timing_gen: pix_tick, h_cnt/v_cnt, region flags; top adds the latency-alignment output stage.

## Test plan
- Reset release, rd_data=8'hAA constant -> outputs at reset values; first pixel 8'hAA on VGA_R/G/B 2 cycles after counters reach (0,0); BLANK_N high.
- Measure one full line -> HS low exactly 192 cycles starting 1312 cycles after line start; line period 1600 cycles.
- Measure frame -> VS low 2 lines (3200 cycles) starting at line 490; frame_start period 840000 cycles, width 1.
- Model buffer (rd_data = rd_x[7:0] ^ rd_y[7:0], 1-cycle registered) -> every active output pixel equals x^y of its position; all blanked pixels 0.
- Blanking -> during h_cnt≥640 or v_cnt≥480, rd_x=rd_y=0 and BLANK_N=0.
- Assert reset at (300,200) for 1 cycle -> counters restart at (0,0), no frame_start pulse, sync levels inactive immediately.
